// File: rtl/hi_lo_muldiv.sv
// hi_lo_muldiv: sequential 32x32 multiply/divide unit that owns the HI/LO registers.
//
// One radix-2 step is done per clock. A multiply or divide takes 33 cycles:
// 32 iterations in RUN, then one FINISH cycle. HI/LO are written on the edge
// that leaves FINISH.
//
// Ports:
//   Clk       - clock, rising edge
//   Rst       - asynchronous active-high reset
//   Start     - launch an operation (honoured only in IDLE without Flush)
//   Op        - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B      - multiplicand/dividend and multiplier/divisor
//   MTHI/MTLO - in IDLE, write MoveData into HI/LO
//   MoveData  - write data for MTHI/MTLO
//   Flush     - abort the in-flight operation, leaving HI/LO untouched
//   HI, LO    - architectural HI/LO registers
//   Busy      - high in RUN or FINISH
//   Done      - high in FINISH only
module hi_lo_muldiv (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] MoveData,
    input  logic        Flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    // acc_hi/acc_lo: running product {hi,lo} for multiply; remainder and
    // dividend-shifting-into-quotient for divide.
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [31:0] opnd_q, opnd_d;
    logic        neg_main_q, neg_main_d;   // negate product / quotient
    logic        neg_rem_q, neg_rem_d;     // negate remainder
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand magnitudes and signs; only MULT/DIV (Op[0]=0) are signed.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // One iteration of each algorithm.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;

    // Final sign-corrected results.
    logic [63:0] prod_mag, prod_res;
    logic [31:0] quo_res, rem_res;

    always_comb begin
        a_neg = ~Op[0] & A[31];
        b_neg = ~Op[0] & B[31];
        a_mag = a_neg ? (~A + 32'd1) : A;
        b_mag = b_neg ? (~B + 32'd1) : B;

        mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : 32'd0)};
        // Partial remainder is always below the divisor, so the top bit of the
        // 33-bit difference is a reliable "borrow" flag.
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};

        prod_mag = {acc_hi_q, acc_lo_q};
        prod_res = neg_main_q ? (~prod_mag + 64'd1) : prod_mag;
        quo_res  = neg_main_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
        rem_res  = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (Start && !Flush) begin
                    state_d  = RUN;
                    cnt_d    = 5'd0;
                    is_div_d = Op[1];
                    acc_hi_d = 32'd0;
                    if (Op[1]) begin
                        acc_lo_d = a_mag;
                        opnd_d   = b_mag;
                        // Divide-by-zero keeps the all-ones quotient un-negated
                        // and lets the remainder rebuild A exactly.
                        neg_main_d = (a_neg ^ b_neg) & (B != 32'd0);
                    end else begin
                        acc_lo_d   = b_mag;
                        opnd_d     = a_mag;
                        neg_main_d = a_neg ^ b_neg;
                    end
                    neg_rem_d = a_neg;
                end else begin
                    if (MTHI) hi_d = MoveData;
                    if (MTLO) lo_d = MoveData;
                end
            end
            RUN: begin
                if (Flush) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[32]) begin
                            acc_hi_d = div_diff[31:0];
                            acc_lo_d = {acc_lo_q[30:0], 1'b1};
                        end else begin
                            acc_hi_d = div_shift[31:0];
                            acc_lo_d = {acc_lo_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum[32:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!Flush) begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = prod_res[63:32];
                        lo_d = prod_res[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
            opnd_q     <= 32'd0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = (state_q != IDLE);
    assign Done = (state_q == FINISH);

endmodule

// File: doc/hi_lo_muldiv.md
HI_LO_MULDIV -- requirements
Module: HiLoMulDiv

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port Start  input  1  launch a multiply/divide; driven from the execute-stage control decoded in the Decode/Execute register.
REQ-004 SHALL have port Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports A, B  input  32 each  operands; A is multiplicand or dividend, B is multiplier or divisor.
REQ-006 SHALL have ports MTHI, MTLO  input  1 each  direct writes of MoveData into HI or LO.
REQ-007 SHALL have port MoveData  input  32  write data for MTHI/MTLO.
REQ-008 SHALL have port Flush  input  1  abort the in-flight operation.
REQ-009 SHALL have ports HI, LO  output  32 each  architectural HI/LO registers.
REQ-010 SHALL have port Busy  output  1  high in RUN or FINISH; pipeline stalls MFHI/MFLO/MT*/Start on it.
REQ-011 SHALL have port Done  output  1  high only in FINISH.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, FINISH, plus a 5-bit iteration counter Cnt.
REQ-013 SHALL, in IDLE with Start=1 at edge k, latch Op and operands (signed ops: magnitudes plus result-sign bits), set Cnt=0, and enter RUN.
REQ-014 SHALL perform one radix-2 iteration per edge in RUN: shift-add for multiply, restoring subtract-shift for divide; Cnt increments and wraps from 31 to 0.
REQ-015 SHALL enter FINISH at edge k+32, after the 32nd iteration, and return to IDLE at edge k+33, writing HI/LO on that same edge.
REQ-016 SHALL produce for multiply a 64-bit product with HI=[63:32] and LO=[31:0]; MULT is two's-complement signed and MULTU unsigned.
REQ-017 SHALL produce for divide LO=quotient and HI=remainder; DIV truncates toward zero and the remainder takes the dividend's sign.
REQ-018 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0x00000000, with no trap.
REQ-019 SHALL, for divisor zero, produce HI=A and LO=0xFFFFFFFF with the same 33-cycle latency.
REQ-020 SHALL ignore Start when not IDLE.
REQ-021 SHALL, in IDLE, write MoveData into HI when MTHI=1 and into LO when MTLO=1 at the edge; both may be set in the same cycle.
REQ-022 SHALL ignore MTHI/MTLO when not IDLE.
REQ-023 SHALL, when Start and MTHI/MTLO are both high in IDLE, accept Start and drop the move.
REQ-024 SHALL, when Flush=1 at an edge in RUN or FINISH, return to IDLE with HI/LO unchanged; Flush takes priority over the FINISH write.
REQ-025 SHALL treat Flush in IDLE as a no-op that also suppresses a same-cycle Start, but not MTHI/MTLO.
REQ-026 SHALL drive Busy and Done combinationally from state only, with no dependence on inputs.

Reset
REQ-027 SHALL, while Rst=1 and independent of Clk, force state IDLE, Cnt=0, all datapath registers to 0, HI=0, LO=0, Busy=0, and Done=0.
REQ-028 SHALL, when reset is asserted mid-operation, discard that operation with no partial HI/LO write.
REQ-029 SHALL accept Start from the first rising edge after Rst deasserts.

Verification
REQ-030 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> Busy=1 for 33 cycles, Done=1 in cycle 33, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-031 SHALL cover: MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; repeat as MULT -> HI=0, LO=1.
REQ-032 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-033 SHALL cover: DIVU A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 SHALL cover: MTHI 0xAAAA5555 with MTLO 0x5555AAAA in IDLE -> both written; MTHI during RUN -> ignored; Start+MTLO together -> MTLO dropped.
REQ-035 SHALL cover: Flush at Cnt=10 -> IDLE next edge with HI/LO unchanged; Rst pulse between edges mid-RUN -> immediate HI=LO=0, Busy=0, and a new Start afterward completes correctly.
